// File: rtl/boot_rom_loader.sv
// Boot ROM loader: validates the ROM header word, then copies the payload into RAM
// over a valid/ready write port and raises a sticky done (or error) flag.
module boot_rom_loader #(
  parameter logic [15:0] MAGIC    = 16'hB007,
  parameter logic [15:0] RAM_BASE = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic [15:0] rom_address,
  input  logic [31:0] rom_data,
  output logic [15:0] ram_address,
  output logic [31:0] ram_data,
  output logic        ram_write,
  input  logic        ram_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_copied
);

  typedef enum logic [2:0] {IDLE, HEADER, FETCH, WRITE, DONE, ERROR} state_t;

  state_t      state;
  logic [15:0] len;
  logic [15:0] rom_ptr;
  logic [15:0] ram_ptr;

  // Single registered FSM; every output is a flop updated on the transition edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      rom_address  <= 16'h0000;
      ram_address  <= 16'h0000;
      ram_data     <= 32'h0000_0000;
      ram_write    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_copied <= 16'h0000;
      len          <= 16'h0000;
      rom_ptr      <= 16'h0000;
      ram_ptr      <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          rom_address <= 16'h0000;
          if (start) begin
            busy         <= 1'b1;
            words_copied <= 16'h0000;
            state        <= HEADER;
          end
        end

        HEADER: begin
          if (rom_data[31:16] != MAGIC) begin
            busy  <= 1'b0;
            error <= 1'b1;
            state <= ERROR;
          end else if (rom_data[15:0] == 16'h0000) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            len          <= rom_data[15:0];
            rom_ptr      <= 16'h0001;
            ram_ptr      <= RAM_BASE;
            words_copied <= 16'h0000;
            rom_address  <= 16'h0001;
            state        <= FETCH;
          end
        end

        FETCH: begin
          ram_data    <= rom_data;
          ram_address <= ram_ptr;
          ram_write   <= 1'b1;
          state       <= WRITE;
        end

        // Address and data stay frozen until the RAM accepts the word.
        WRITE: begin
          if (ram_ready) begin
            ram_write    <= 1'b0;
            words_copied <= words_copied + 16'd1;
            rom_ptr      <= rom_ptr + 16'd1;
            ram_ptr      <= ram_ptr + 16'd1;
            if (words_copied + 16'd1 == len) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              rom_address <= rom_ptr + 16'd1;
              state       <= FETCH;
            end
          end
        end

        DONE, ERROR: begin
          if (start) begin
            done         <= 1'b0;
            error        <= 1'b0;
            words_copied <= 16'h0000;
            rom_address  <= 16'h0000;
            busy         <= 1'b1;
            state        <= HEADER;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_rom_loader.sv
// Directed bench for boot_rom_loader: small ROM model, RAM write log and
// edge-accurate timing checks against hand-derived latencies.
module tb_boot_rom_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        ram_ready = 1'b1;
  logic [15:0] rom_address;
  logic [31:0] rom_data;
  logic [15:0] ram_address;
  logic [31:0] ram_data;
  logic        ram_write;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_copied;

  logic [31:0] rom [0:15];

  int testsRun = 0;
  int testsFailed = 0;
  int cyc = 0;

  logic [15:0] wrAddr [$];
  logic [31:0] wrData [$];
  int          wrEdge [$];

  int   stallCount = 0;
  int   stallSeen = 0;
  logic stallStable = 1'b1;

  int   k;
  int   doneEdge;
  int   errEdge;
  logic busyAfter;
  logic flagsAfter;

  always #5 clk = ~clk;

  assign rom_data = (rom_address < 16'd16) ? rom[rom_address[3:0]] : 32'h0;

  boot_rom_loader dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .rom_address  (rom_address),
    .rom_data     (rom_data),
    .ram_address  (ram_address),
    .ram_data     (ram_data),
    .ram_write    (ram_write),
    .ram_ready    (ram_ready),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_copied (words_copied)
  );

  // Edge counter and RAM transfer log; an edge with reset low abandons the write.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset_n && ram_write && ram_ready) begin
      wrAddr.push_back(ram_address);
      wrData.push_back(ram_data);
      wrEdge.push_back(cyc + 1);
    end
  end

  // Back-pressure generator: holds ram_ready low while word 1 is offered.
  always @(negedge clk) begin
    if (stallCount > 0 && ram_write && ram_address == 16'd1) begin
      ram_ready = 1'b0;
      stallCount--;
      stallSeen++;
      if (ram_data !== 32'h22222222 || ram_address !== 16'd1) stallStable = 1'b0;
    end else begin
      ram_ready = 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Pulses start, records when done/error rise, optionally pulses start again mid-load.
  task automatic applyStimulus(input int pulseAt, input int budget);
    wrAddr.delete();
    wrData.delete();
    wrEdge.delete();
    doneEdge = -1;
    errEdge  = -1;
    @(negedge clk);
    start = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    busyAfter  = busy;
    flagsAfter = done | error;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      start = (pulseAt > 0 && cyc == k + pulseAt) ? 1'b1 : 1'b0;
      if (done && doneEdge < 0) doneEdge = cyc;
      if (error && errEdge < 0) errEdge = cyc;
      if (doneEdge >= 0 || errEdge >= 0) break;
    end
    start = 1'b0;
    if (doneEdge < 0 && errEdge < 0) checkOutput("load timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic checkLoad3(input string name, input bit stalled);
    int expEdge [3];
    expEdge[0] = k + 3;
    expEdge[1] = stalled ? k + 8 : k + 5;
    expEdge[2] = stalled ? k + 10 : k + 7;
    checkOutput({name, " busy after start"}, busyAfter, 1'b1);
    checkOutput({name, " flags cleared"}, flagsAfter, 1'b0);
    checkOutput({name, " write count"}, wrAddr.size(), 3);
    for (int i = 0; i < 3 && i < wrAddr.size(); i++) begin
      checkOutput($sformatf("%s addr%0d", name, i), wrAddr[i], 16'h0000 + i);
      checkOutput($sformatf("%s data%0d", name, i), wrData[i], 32'h11111111 * (i + 1));
      checkOutput($sformatf("%s edge%0d", name, i), wrEdge[i] - k, expEdge[i] - k);
    end
    checkOutput({name, " done edge"}, doneEdge - k, expEdge[2] - k);
    checkOutput({name, " done"}, done, 1'b1);
    checkOutput({name, " error"}, error, 1'b0);
    checkOutput({name, " busy"}, busy, 1'b0);
    checkOutput({name, " words_copied"}, words_copied, 16'd3);
    checkOutput({name, " ram_write low"}, ram_write, 1'b0);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, " rom_address"}, rom_address, 16'h0);
    checkOutput({name, " ram_address"}, ram_address, 16'h0);
    checkOutput({name, " ram_data"}, ram_data, 32'h0);
    checkOutput({name, " ram_write"}, ram_write, 1'b0);
    checkOutput({name, " busy"}, busy, 1'b0);
    checkOutput({name, " done"}, done, 1'b0);
    checkOutput({name, " error"}, error, 1'b0);
    checkOutput({name, " words_copied"}, words_copied, 16'h0);
  endtask

  initial begin
    bit found;
    reset_n = 1'b0;
    start   = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 32'h0;
    rom[0] = 32'hB007_0003;
    rom[1] = 32'h11111111;
    rom[2] = 32'h22222222;
    rom[3] = 32'h33333333;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Normal three-word load from IDLE
    applyStimulus(0, 40);
    checkLoad3("load3", 1'b0);

    // Bad magic, twice in a row
    rom[0] = 32'hDEAD_0003;
    for (int r = 0; r < 2; r++) begin
      applyStimulus(0, 40);
      checkOutput($sformatf("magic%0d flags cleared", r), flagsAfter, 1'b0);
      checkOutput($sformatf("magic%0d error edge", r), errEdge - k, 1);
      checkOutput($sformatf("magic%0d error", r), error, 1'b1);
      checkOutput($sformatf("magic%0d done", r), done, 1'b0);
      checkOutput($sformatf("magic%0d writes", r), wrAddr.size(), 0);
      checkOutput($sformatf("magic%0d busy", r), busy, 1'b0);
    end

    // Zero-length payload
    rom[0] = 32'hB007_0000;
    applyStimulus(0, 40);
    checkOutput("len0 done edge", doneEdge - k, 1);
    checkOutput("len0 done", done, 1'b1);
    checkOutput("len0 error", error, 1'b0);
    checkOutput("len0 writes", wrAddr.size(), 0);
    checkOutput("len0 words_copied", words_copied, 16'd0);

    // Back-pressure on word 1
    rom[0] = 32'hB007_0003;
    stallSeen   = 0;
    stallStable = 1'b1;
    stallCount  = 3;
    applyStimulus(0, 60);
    checkLoad3("stall", 1'b1);
    checkOutput("stall cycles", stallSeen, 3);
    checkOutput("stall hold stable", stallStable, 1'b1);

    // Reset while word 1 is being offered
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (ram_write && ram_address == 16'd1) found = 1'b1;
    end
    checkOutput("reset reached word1", found, 1'b1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checkAllZero("midreset");
    applyStimulus(0, 40);
    checkLoad3("after reset", 1'b0);

    // Start pulsed while busy is ignored
    applyStimulus(3, 40);
    checkLoad3("busy start", 1'b0);

    // Restart straight from DONE repeats the load
    applyStimulus(0, 40);
    checkLoad3("restart", 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
